// File: rtl/cdm_pkg.sv
// Shared types and helpers for the carry-disregard multiplier family.
package cdm_pkg;

    // Largest operand width the helper functions are sized for.
    localparam int CDM_MAX_W = 32;
    localparam int CDM_MAX_P = 2 * CDM_MAX_W;

    typedef enum logic [1:0] {
        CDM_IDLE = 2'd0,
        CDM_BUSY = 2'd1,
        CDM_DONE = 2'd2
    } cdm_state_t;

    // Saturate the boundary at 2w: anything larger means "all columns approximate".
    function automatic int cdm_clamp_k(input int k, input int w);
        if (k > 2 * w) begin
            return 2 * w;
        end else begin
            return k;
        end
    endfunction

    // Mask of product columns j with k <= j < 2w; the columns summed exactly.
    function automatic logic [CDM_MAX_P-1:0] cdm_hi_mask(input int k, input int w);
        logic [CDM_MAX_P-1:0] m;
        m = '0;
        for (int j = 0; j < CDM_MAX_P; j++) begin
            if ((j < 2 * w) && (j >= k)) begin
                m[j] = 1'b1;
            end else begin
                m[j] = 1'b0;
            end
        end
        return m;
    endfunction

    // Reference product: row-serial accumulation over the full operand width.
    function automatic logic [CDM_MAX_P-1:0] cdm_ref(
        input logic [CDM_MAX_W-1:0] a,
        input logic [CDM_MAX_W-1:0] b,
        input int                   k,
        input int                   w
    );
        logic [CDM_MAX_P-1:0] hm;
        logic [CDM_MAX_P-1:0] pm;
        logic [CDM_MAX_P-1:0] acc;
        logic [CDM_MAX_P-1:0] par;
        logic [CDM_MAX_P-1:0] row;
        hm  = cdm_hi_mask(cdm_clamp_k(k, w), w);
        pm  = cdm_hi_mask(0, w);
        acc = '0;
        par = '0;
        for (int r = 0; r < CDM_MAX_W; r++) begin
            if ((r < w) && b[r]) begin
                row = {{CDM_MAX_W{1'b0}}, a} << r;
            end else begin
                row = '0;
            end
            acc = (acc + (row & hm)) & pm;
            par = par ^ (row & ~hm);
        end
        return (acc | par) & pm;
    endfunction

endpackage

// File: rtl/cdm_row_acc.sv
// One multiplier-row step: exact add above the boundary, XOR parity below it.
module cdm_row_acc #(
    parameter int W = 8
) (
    input  logic [2*W-1:0] i_acc,
    input  logic [2*W-1:0] i_par,
    input  logic [2*W-1:0] i_row,
    input  logic [2*W-1:0] i_hm,
    output logic [2*W-1:0] o_acc,
    output logic [2*W-1:0] o_par
);

    // Fold one shifted partial-product row into the accumulator and parity.
    always_comb begin
        o_acc = i_acc + (i_row & i_hm);
        o_par = i_par ^ (i_row & ~i_hm);
    end

endmodule

// File: rtl/cdm_seq_mult.sv
// Sequential carry-disregard multiplier: one multiplier row per cycle,
// run-time selectable approximation boundary, valid/ready on both sides.
module cdm_seq_mult
    import cdm_pkg::*;
#(
    parameter int W  = 8,
    parameter int KW = $clog2(2 * W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [KW-1:0] approx_cols,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2*W-1:0] p
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int PW = 2 * W;

    cdm_state_t      r_state;
    cdm_state_t      w_state_nxt;
    logic            w_accept;
    logic            w_last;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [KW-1:0]   r_k;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_acc;
    logic [PW-1:0]   r_par;
    logic [PW-1:0]   r_p;
    logic [PW-1:0]   w_row;
    logic [PW-1:0]   w_hm;
    logic [PW-1:0]   w_acc_nxt;
    logic [PW-1:0]   w_par_nxt;
    logic [KW-1:0]   w_k_clamp;
    logic [CDM_MAX_P-1:0] w_hm_full;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign p         = r_p;

    // Boundary clamp at the input and column mask from the latched boundary.
    always_comb begin
        w_k_clamp = KW'(cdm_clamp_k(int'(approx_cols), W));
        w_hm_full = cdm_hi_mask(int'(r_k), W);
        w_hm      = w_hm_full[PW-1:0];
    end

    // Current partial-product row: a gated by multiplier bit r, shifted by r.
    always_comb begin
        w_row = {{W{1'b0}}, r_a & {W{r_b[r_cnt]}}} << r_cnt;
    end

    cdm_row_acc #(.W(W)) u_row_acc (
        .i_acc (r_acc),
        .i_par (r_par),
        .i_row (w_row),
        .i_hm  (w_hm),
        .o_acc (w_acc_nxt),
        .o_par (w_par_nxt)
    );

    // Next-state logic for IDLE -> BUSY -> DONE -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            CDM_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = CDM_BUSY;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = CDM_IDLE;
                end
            end
            CDM_BUSY: begin
                if (r_cnt == CW'(W - 1)) begin
                    w_state_nxt = CDM_DONE;
                    w_last      = 1'b1;
                end else begin
                    w_state_nxt = CDM_BUSY;
                end
            end
            CDM_DONE: begin
                if (out_ready) begin
                    w_state_nxt = CDM_IDLE;
                end else begin
                    w_state_nxt = CDM_DONE;
                end
            end
            default: begin
                w_state_nxt = CDM_IDLE;
            end
        endcase
    end

    // State register with handshake flags decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= CDM_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == CDM_IDLE);
            r_out_valid <= (w_state_nxt == CDM_DONE);
        end
    end

    // Operand capture at accept, row accumulation while busy, result capture on the last row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_k   <= '0;
            r_cnt <= '0;
            r_acc <= '0;
            r_par <= '0;
            r_p   <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_k   <= w_k_clamp;
            r_cnt <= '0;
            r_acc <= '0;
            r_par <= '0;
        end else if (r_state == CDM_BUSY) begin
            r_acc <= w_acc_nxt;
            r_par <= w_par_nxt;
            if (w_last) begin
                r_cnt <= '0;
                r_p   <= w_acc_nxt | w_par_nxt;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: tb/tb_cdm_seq_mult.sv
// Self-checking bench for cdm_seq_mult at W=8 with a queue-based scoreboard.
module tb_cdm_seq_mult;

    localparam int W  = 8;
    localparam int KW = $clog2(2 * W + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [KW-1:0] approx_cols;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] p;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    logic [15:0] exp_q [$];

    cdm_seq_mult #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .approx_cols (approx_cols),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .p           (p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Column-wise model: count the AND terms of every column, keep parity
    // below the boundary and add the column weight times the count above it.
    function automatic logic [15:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic [4:0] mk);
        int          kk;
        int          cnt;
        logic [15:0] res;
        logic [31:0] hi;
        kk  = (int'(mk) > 16) ? 16 : int'(mk);
        res = 16'h0000;
        hi  = 32'h0;
        for (int j = 0; j < 16; j++) begin
            cnt = 0;
            for (int i = 0; i < 8; i++) begin
                if ((j - i >= 0) && (j - i < 8)) begin
                    if (ma[i] && mb[j - i]) cnt++;
                end
            end
            if (j < kk) res[j] = cnt[0];
            else        hi = hi + (32'(cnt) << j);
        end
        return res | hi[15:0];
    endfunction

    // Drive one request once in_ready is seen, then scramble the inputs.
    task automatic do_req(input logic [7:0] ta, input logic [7:0] tb, input logic [4:0] tk);
        int waited;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        a = ta; b = tb; approx_cols = tk; in_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc     = cyc;
        in_valid    = 1'b0;
        a           = 8'($urandom);
        b           = 8'($urandom);
        approx_cols = 5'($urandom);
    endtask

    // Wait (bounded) for out_valid, capture p and latency, stall, then handshake.
    task automatic get_out(input int stall, output logic [15:0] pv, output int lat, output bit ok);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        ok  = out_valid;
        lat = cyc - acc_cyc;
        pv  = p;
        repeat (stall) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 8'h00; b = 8'h00; approx_cols = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_checks++;
        if (p !== 16'h0000) begin n_fail++; $display("FAIL reset_p: got %h want 0000", p); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_flags: in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [7:0]  ta [7];
        logic [7:0]  tb [7];
        logic [4:0]  tk [7];
        logic [15:0] tp [7];
        logic [15:0] pv;
        logic [15:0] e;
        int          lat;
        bit          ok;
        ta = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'hC3};
        tb = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hA5, 8'h80, 8'h00};
        tk = '{5'd0,  5'd8,  5'd16, 5'd31, 5'd5,  5'd7,  5'd12};
        tp = '{16'hFE01, 16'hF755, 16'h5555, 16'h5555, 16'h0000, 16'h0080, 16'h0000};
        for (int i = 0; i < 7; i++) begin
            do_req(ta[i], tb[i], tk[i]);
            exp_q.push_back(model(ta[i], tb[i], tk[i]));
            get_out(0, pv, lat, ok);
            e = exp_q.pop_front();
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL dir_timeout[%0d]: out_valid=0 want 1", i); end
            n_checks++;
            if (pv !== e) begin n_fail++; $display("FAIL dir_model[%0d]: got %h want %h", i, pv, e); end
            n_checks++;
            if (pv !== tp[i]) begin n_fail++; $display("FAIL dir_const[%0d]: got %h want %h", i, pv, tp[i]); end
            n_checks++;
            if (lat !== W) begin n_fail++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, W); end
        end
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL dir_idle: in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] e;
        int          n;
        do_req(8'h5A, 8'h3C, 5'd4);
        exp_q.push_back(model(8'h5A, 8'h3C, 5'd4));
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        e = exp_q.pop_front();
        for (int i = 0; i < 20; i++) begin
            if (i == 3) begin
                a = 8'hFF; b = 8'hFF; approx_cols = 5'd0; in_valid = 1'b1;
            end
            n_checks++;
            if (p !== e) begin n_fail++; $display("FAIL bp_p[%0d]: got %h want %h", i, p, e); end
            n_checks++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, out_valid); end
            n_checks++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %0b want 0", i, in_ready); end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_ignored[%0d]: out_valid=%0b want 0", i, out_valid); end
        end
    endtask

    task automatic test_reset_midop();
        logic [15:0] pv;
        logic [15:0] e;
        int          lat;
        bit          ok;
        do_req(8'hFF, 8'hFF, 5'd0);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_flags: out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_out[%0d]: out_valid=%0b want 0", i, out_valid); end
        end
        do_req(8'h03, 8'h03, 5'd0);
        exp_q.push_back(model(8'h03, 8'h03, 5'd0));
        get_out(2, pv, lat, ok);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || pv !== e) begin n_fail++; $display("FAIL rst_after_model: got %h ok=%0b want %h", pv, ok, e); end
        n_checks++;
        if (pv !== 16'h0009) begin n_fail++; $display("FAIL rst_after_const: got %h want 0009", pv); end
    endtask

    task automatic test_random();
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [4:0]  rk;
        logic [15:0] pv;
        logic [15:0] e;
        int          lat;
        int          prev;
        bit          ok;
        prev = 0;
        for (int n = 0; n < 400; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rk = 5'($urandom_range(0, 2 * W + 3));
            do_req(ra, rb, rk);
            if (n > 0) begin
                n_checks++;
                if (acc_cyc - prev < W + 2) begin
                    n_fail++; $display("FAIL rnd_ii[%0d]: got %0d want >=%0d", n, acc_cyc - prev, W + 2);
                end
            end
            prev = acc_cyc;
            exp_q.push_back(model(ra, rb, rk));
            get_out($urandom_range(0, 3), pv, lat, ok);
            e = exp_q.pop_front();
            n_checks++;
            if (!ok || pv !== e) begin
                n_fail++; $display("FAIL rnd_p[%0d]: a=%h b=%h k=%0d got %h ok=%0b want %h", n, ra, rb, rk, pv, ok, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdm_seq_mult.md
# cdm_seq_mult

Parametrised, sequential carry-disregard multiplier (CDM) for unsigned operands. The carry-disregard boundary is selected at run time per transaction; it spans anywhere from fully exact to fully approximate. Columns below the boundary combine partial products by XOR only, with carries discarded. Columns at or above the boundary are summed exactly. The block processes one multiplier row per cycle behind valid/ready handshakes, so it is the area-lean alternative to the fixed-width combinational CDM arrays, for datapaths that tolerate multi-cycle latency.

## Interface
Parameters:
- `W`, default 8: operand width; product is 2W bits; W ≥ 2.
- `KW`, default $clog2(2W+1): width of the boundary input (derived, not overridden).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: operand/boundary request valid.
- `in_ready` out 1: block can accept a request.
- `a` in W: multiplicand, unsigned.
- `b` in W: multiplier, unsigned.
- `approx_cols` in KW: carry-disregard boundary K; values above 2W are treated as 2W.
- `out_valid` out 1: product valid.
- `out_ready` in 1: consumer accepts the product.
- `p` out 2W: product.

## Operation
- Definition, with K the clamped boundary:
  - Low region, bit j < K: p[j] = XOR over all i+k=j of a[i]&b[k].
  - High region: p[2W-1:K] equals the exact sum over all i+k ≥ K of a[i]&b[k]·2^(i+k), shifted right by K and truncated to 2W-K bits.
  - K=0 gives the exact product; K=2W gives pure parity.
- Registers:
  - acc (2W): exact high-region accumulator.
  - par (2W): low-region parity.
  - a_r, b_r, k_r: operands and boundary, latched at accept.
  - row counter (clog2 W bits).
  - mask: HM = columns ≥ k_r.
- Per row r, with row = (a_r & {W{b_r[r]}}) << r, zero-extended to 2W:
  - acc += row & HM, modulo 2^2W.
  - par ^= row & ~HM.
- Result: p = acc | par. The regions are disjoint, so OR is exact.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid: latch a, b, clamped K; clear acc, par and counter; go to BUSY.
  - BUSY: process row `counter`, one per cycle. After row W-1, go to DONE.
  - DONE: out_valid=1; p is stable. On out_ready, go to IDLE.
- Handshake rules:
  - in_ready is high only in IDLE. Requests are never accepted in BUSY or DONE.
  - p and out_valid hold steady until out_ready is sampled high.
  - in_valid may drop while in_ready is low without any effect.
- Boundary conditions:
  - b=0 or a=0: p=0 for every K.
  - approx_cols > 2W (for example all ones in KW bits): behaves exactly as 2W.
  - K is sampled once at accept. Changes during BUSY are ignored.
  - rst asserted mid-BUSY or mid-DONE: the transaction is discarded, the FSM returns to IDLE, and no out_valid is produced.

## Timing
- Reset values: in_ready=1, out_valid=0, p=0 (acc=par=0), state=IDLE, counter=0.
- Accept at edge t. Rows are processed at edges t+1 … t+W. out_valid is high after edge t+W.
- Latency: W cycles from accept to out_valid.
- Minimum initiation interval: W+2 cycles (accept, W rows, output acceptance in DONE, return to IDLE).
- out_valid & out_ready at edge u: out_valid=0 and in_ready=1 after edge u. The next accept is possible at edge u+1.
- No combinational path from in_valid or out_ready to any output.

## Structure
- Shared package `cdm_pkg`:
  - function `cdm_clamp_k(k, W)`.
  - function `cdm_hi_mask(k, W)`, which returns the 2W-bit mask of columns ≥ k.
  - FSM state enum `cdm_state_t`.
  - A reference-model function `cdm_ref(a, b, k)` for benches.
- One sub-module, `cdm_row_acc`: a combinational row step that takes acc, par, row and HM and produces the next acc and par. It is reusable later for an unrolled pipelined variant. The FSM, counter and handshake live in the top module.

## Test plan
- W=8, a=0xFF, b=0xFF, K=0 → p=0xFE01, out_valid after exactly 8 cycles.
- W=8, a=0xFF, b=0xFF, K=8 → p=0xF755. With K=16 → p=0x5555. With approx_cols=31 (clamped) → p=0x5555.
- W=8, a=0x00, b=0xA5, K=5 → p=0x0000. Then a=0x01, b=0x80, K=7 → p=0x0080.
- Backpressure: hold out_ready=0 for 20 cycles after completion. p is stable and in_ready=0 throughout. A new in_valid during that time is ignored.
- Reset mid-op: assert rst at row 4 of a=0xFF, b=0xFF. out_valid never rises. After release, a=0x03, b=0x03, K=0 → p=0x0009.
- Randomised: 10k requests with random a, b and K (0..2W+3) at W=8 and W=16, with random out_ready stalls. p must match cdm_ref, and initiation interval must be ≥ W+2.
